ls_counter_n: RTL and testbench

LS_COUNTER_N -- requirements
Module: ls_counter_n

---
 rtl/ls_counter_pkg.sv | 12 +
 rtl/ls_counter_next.sv | 29 ++
 rtl/ls_counter_n.sv | 89 ++++++++
 tb/tb_ls_counter_n.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ls_counter_pkg.sv
// Shared constants and helpers for the ls_counter family of modulo counters.
package ls_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Terminal (last) value of a modulo-MODULUS sequence; caller truncates to WIDTH.
  function automatic logic [31:0] terminal_value(input longint unsigned modulus);
    return 32'(modulus - 64'd1);
  endfunction

endpackage

// File: rtl/ls_counter_next.sv
// Combinational next-count logic for ls_counter_n: modulo up/down step and wrap flag.
module ls_counter_next
  import ls_counter_pkg::*;
#(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  output logic [WIDTH-1:0] q_next,
  output logic             at_term,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(terminal_value(MODULUS));

  always_comb begin
    q_next  = q;
    // Up direction treats any out-of-range loaded value as terminal.
    at_term = (up == DIR_UP) ? (q >= TERM) : (q == '0);
    wrap    = at_term;
    if (up == DIR_UP) begin
      q_next = at_term ? '0 : q + WIDTH'(1);
    end else begin
      q_next = at_term ? TERM : q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/ls_counter_n.sv
// Loadable modulo-N up/down counter with ripple carry and wrap pulse.
// Optional compare/match output enabled by defining LS_COUNTER_MATCH_EN.
module ls_counter_n
  import ls_counter_pkg::*;
#(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic             CLK,
  input  logic             CLR_n,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD_n,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             UP,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             WRAP
`ifdef LS_COUNTER_MATCH_EN
  ,
  input  logic [WIDTH-1:0] CMP,
  output logic             MATCH
`endif
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("ls_counter_n: WIDTH must be in 2..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("ls_counter_n: MODULUS must be in 2..2**WIDTH");
  end

  logic [WIDTH-1:0] q_q, q_d, cnt_next;
  logic             wrap_q, wrap_d;
  logic             cnt_term, cnt_wrap;

  ls_counter_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .q       (q_q),
    .up      (UP),
    .q_next  (cnt_next),
    .at_term (cnt_term),
    .wrap    (cnt_wrap)
  );

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (!LOAD_n) begin
      q_d = D;
    end else if (ENP && ENT) begin
      q_d    = cnt_next;
      wrap_d = cnt_wrap;
    end
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign WRAP = wrap_q;
  assign RCO  = ENT & cnt_term;

`ifdef LS_COUNTER_MATCH_EN
  logic match_q;

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      match_q <= 1'b0;
    end else begin
      match_q <= (q_d == CMP);
    end
  end

  assign MATCH = match_q;
`else
  // No compare state in the base configuration.
`endif

endmodule

// File: tb/tb_ls_counter_n.sv
// Self-checking bench for ls_counter_n: directed scenarios plus randomized run vs. reference model.
module tb_ls_counter_n;

  localparam int MOD = 10;

  logic       CLK = 1'b0;
  logic       CLR_n = 1'b0;
  logic [3:0] D = 4'h0;
  logic       LOAD_n = 1'b1, ENP = 1'b0, ENT = 1'b0, UP = 1'b1;
  logic [3:0] Q;
  logic       RCO, WRAP;

  logic [3:0] c_d_lo = 4'h0, c_d_hi = 4'h0;
  logic       c_load_n = 1'b1, c_ent = 1'b0;
  logic [3:0] c_q_lo, c_q_hi;
  logic       c_rco_lo, c_rco_hi, c_wrap_lo, c_wrap_hi;

`ifdef LS_COUNTER_MATCH_EN
  logic [3:0] CMP = 4'h0;
  logic       MATCH, c_match_lo, c_match_hi;
`endif

  int tests_run = 0;
  int n_fail = 0;
  int mq = 0;
  bit mwrap = 0;
  bit mmatch = 0;
  int cval = 0;

  always #5 CLK = ~CLK;

  ls_counter_n #(.WIDTH(4), .MODULUS(MOD)) u_dut (
    .CLK(CLK), .CLR_n(CLR_n), .D(D), .LOAD_n(LOAD_n), .ENP(ENP), .ENT(ENT), .UP(UP),
    .Q(Q), .RCO(RCO), .WRAP(WRAP)
`ifdef LS_COUNTER_MATCH_EN
    , .CMP(CMP), .MATCH(MATCH)
`endif
  );

  ls_counter_n #(.WIDTH(4)) u_lo (
    .CLK(CLK), .CLR_n(CLR_n), .D(c_d_lo), .LOAD_n(c_load_n), .ENP(1'b1), .ENT(c_ent),
    .UP(1'b1), .Q(c_q_lo), .RCO(c_rco_lo), .WRAP(c_wrap_lo)
`ifdef LS_COUNTER_MATCH_EN
    , .CMP(4'h0), .MATCH(c_match_lo)
`endif
  );

  ls_counter_n #(.WIDTH(4)) u_hi (
    .CLK(CLK), .CLR_n(CLR_n), .D(c_d_hi), .LOAD_n(c_load_n), .ENP(1'b1), .ENT(c_rco_lo),
    .UP(1'b1), .Q(c_q_hi), .RCO(c_rco_hi), .WRAP(c_wrap_hi)
`ifdef LS_COUNTER_MATCH_EN
    , .CMP(4'h0), .MATCH(c_match_hi)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_rco();
    return ENT && (UP ? (mq >= MOD - 1) : (mq == 0));
  endfunction

  // Reference model: one rising edge, straight from the counting rules.
  task automatic model_edge();
    mwrap = 1'b0;
    if (!LOAD_n) begin
      mq = int'(D);
    end else if (ENP && ENT) begin
      if (UP) begin
        if (mq >= MOD - 1) begin mq = 0; mwrap = 1'b1; end
        else mq = mq + 1;
      end else begin
        if (mq == 0) begin mq = MOD - 1; mwrap = 1'b1; end
        else mq = mq - 1;
      end
    end
`ifdef LS_COUNTER_MATCH_EN
    mmatch = (mq == int'(CMP));
`endif
    if (!c_load_n) cval = {24'h0, c_d_hi, c_d_lo};
    else if (c_ent) cval = (cval + 1) % 256;
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    mq = 0; mwrap = 1'b0; mmatch = 1'b0; cval = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q"}, 32'(Q), 32'(mq));
    check({tag, ".wrap"}, 32'(WRAP), 32'(mwrap));
    check({tag, ".rco"}, 32'(RCO), 32'(model_rco()));
`ifdef LS_COUNTER_MATCH_EN
    check({tag, ".match"}, 32'(MATCH), 32'(mmatch));
`endif
  endtask

  initial begin
    // Reset state, and RCO = ENT & ~UP while held in reset
    ENT = 1'b1; UP = 1'b1;
    #12;
    model_reset();
    check_all("reset_up");
    UP = 1'b0; ENP = 1'b1;
    #1;
    check_all("reset_down");

    // First edge after reset counting down wraps to MODULUS-1
    CLR_n = 1'b1;
    tick();
    check_all("down_first");

    // Count up from reset for 12 edges
    CLR_n = 1'b0; #1; model_reset();
    check_all("reset2");
    CLR_n = 1'b1; UP = 1'b1;
    #1;
    check_all("up_pre");
    for (int i = 0; i < 12; i++) begin
      tick();
      check_all($sformatf("up_seq%0d", i));
    end

    // Load an out-of-range value, then count up past it
    LOAD_n = 1'b0; D = 4'hC; ENP = 1'b0;
    tick();
    check_all("load_c");
    LOAD_n = 1'b1; ENP = 1'b1;
    tick();
    check_all("c_wraps");

    // Load at terminal count takes priority, no wrap
    LOAD_n = 1'b0; D = 4'h9;
    tick();
    D = 4'h2;
    tick();
    check_all("load_at_term");
    LOAD_n = 1'b1;

    // Randomized run against the model
`ifdef LS_COUNTER_MATCH_EN
    CMP = 4'h5;
`endif
    for (int i = 0; i < 300; i++) begin
      LOAD_n = ($urandom_range(0, 7) != 0);
      ENP    = ($urandom_range(0, 3) != 0);
      ENT    = ($urandom_range(0, 3) != 0);
      UP     = 1'($urandom_range(0, 1));
      D      = 4'($urandom_range(0, 15));
      #1;
      check("rnd_rco_comb", 32'(RCO), 32'(model_rco()));
      tick();
      check_all("rnd");
    end

`ifdef LS_COUNTER_MATCH_EN
    // Match pulse on count into CMP and on load of CMP
    CMP = 4'h5; UP = 1'b1; ENP = 1'b1; ENT = 1'b1;
    LOAD_n = 1'b0; D = 4'h3;
    tick(); check_all("m_load3");
    LOAD_n = 1'b1;
    tick(); check_all("m_q4");
    tick(); check_all("m_q5");
    tick(); check_all("m_q6");
    LOAD_n = 1'b0; D = 4'h5;
    tick(); check_all("m_load5");
    LOAD_n = 1'b1;
`endif

    // Asynchronous clear mid-cycle while a load is pending
    LOAD_n = 1'b0; D = 4'h7; UP = 1'b1; ENP = 1'b1; ENT = 1'b1;
    tick();
    check_all("pre_clr7");
    D = 4'h3;
    #3;
    CLR_n = 1'b0;
    #1;
    model_reset();
    check_all("clr_immediate");
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      check_all($sformatf("clr_hold%0d", i));
    end
    LOAD_n = 1'b1;
    CLR_n = 1'b1;
    tick();
    check_all("post_clr_edge");

    // Cascade: low RCO drives high ENT
    c_load_n = 1'b0; c_d_lo = 4'hE; c_d_hi = 4'hF;
    tick();
    check("casc_load", 32'({c_q_hi, c_q_lo}), 32'(cval));
    c_load_n = 1'b1; c_ent = 1'b1;
    tick();
    check("casc_ff", 32'({c_q_hi, c_q_lo}), 32'(cval));
    check("casc_ff_rco_hi", 32'(c_rco_hi), 32'd1);
    tick();
    check("casc_00", 32'({c_q_hi, c_q_lo}), 32'(cval));
    check("casc_00_wrap_lo", 32'(c_wrap_lo), 32'd1);
    check("casc_00_wrap_hi", 32'(c_wrap_hi), 32'd1);
`ifdef LS_COUNTER_MATCH_EN
    check("casc_00_match", 32'({c_match_hi, c_match_lo}), 32'd3);
`endif
    for (int i = 0; i < 60; i++) begin
      c_ent = ($urandom_range(0, 3) != 0);
      tick();
      check("casc_rnd", 32'({c_q_hi, c_q_lo}), 32'(cval));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, n_fail);
    $finish;
  end

endmodule
